// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that frames temperature/humidity payloads into 5-byte UART packets
// (0xAA, tag, payload hi, payload lo, checksum) and hands them byte-wise to a UART transmitter.
module uart_frame_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_t,
    input  logic [15:0] data_t,
    input  logic        req_h,
    input  logic [15:0] data_h,
    output logic        ack_t,
    output logic        ack_h,
    output logic        err,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWaitAcc,
        StWaitDone,
        StDone,
        StAbort
    } state_e;

    localparam logic       SrcT = 1'b0;
    localparam logic       SrcH = 1'b1;
    localparam logic [7:0] TagT = 8'h54;
    localparam logic [7:0] TagH = 8'h48;

    state_e      r_state;
    logic [2:0]  r_byte_idx;
    logic [2:0]  r_timeout;
    logic        r_last_grant;
    logic        r_grant;
    logic [15:0] r_payload;
    logic [7:0]  r_tx_data;

    state_e      w_state_next;
    logic [2:0]  w_byte_idx_next;
    logic [2:0]  w_timeout_next;
    logic        w_last_grant_next;
    logic        w_grant_next;
    logic [15:0] w_payload_next;
    logic [7:0]  w_tx_data_next;
    logic        w_arb_src;
    logic        w_finish;

    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic src,
                                              input logic [15:0] payload);
        logic [7:0] tag;
        tag = (src == SrcH) ? TagH : TagT;
        case (idx)
            3'd0:    frame_byte = 8'hAA;
            3'd1:    frame_byte = tag;
            3'd2:    frame_byte = payload[15:8];
            3'd3:    frame_byte = payload[7:0];
            default: frame_byte = tag + payload[15:8] + payload[7:0];
        endcase
    endfunction

    // H wins only if T is idle, or both request and T was the previous grant.
    assign w_arb_src = req_h & (~req_t | (r_last_grant == SrcT));

    always_comb begin
        w_state_next      = r_state;
        w_byte_idx_next   = r_byte_idx;
        w_timeout_next    = r_timeout;
        w_last_grant_next = r_last_grant;
        w_grant_next      = r_grant;
        w_payload_next    = r_payload;
        w_tx_data_next    = r_tx_data;
        case (r_state)
            StIdle: begin
                if (!tx_busy && (req_t || req_h)) begin
                    w_grant_next      = w_arb_src;
                    w_last_grant_next = w_arb_src;
                    w_payload_next    = (w_arb_src == SrcH) ? data_h : data_t;
                    w_byte_idx_next   = 3'd0;
                    w_tx_data_next    = 8'hAA;
                    w_state_next      = StSend;
                end
            end
            StSend: w_state_next = StWaitAcc;
            StWaitAcc: begin
                if (tx_busy) begin
                    w_timeout_next = 3'd0;
                    w_state_next   = StWaitDone;
                end else if (r_timeout == 3'd7) begin
                    w_timeout_next = 3'd0;
                    w_state_next   = StAbort;
                end else begin
                    w_timeout_next = r_timeout + 3'd1;
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    if (r_byte_idx < 3'd4) begin
                        w_byte_idx_next = r_byte_idx + 3'd1;
                        w_tx_data_next  = frame_byte(r_byte_idx + 3'd1, r_grant, r_payload);
                        w_state_next    = StSend;
                    end else begin
                        w_state_next = StDone;
                    end
                end
            end
            StDone:  w_state_next = StIdle;
            StAbort: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_byte_idx   <= 3'd0;
            r_timeout    <= 3'd0;
            r_last_grant <= SrcH;
            r_grant      <= SrcT;
            r_payload    <= 16'h0000;
            r_tx_data    <= 8'h00;
        end else begin
            r_state      <= w_state_next;
            r_byte_idx   <= w_byte_idx_next;
            r_timeout    <= w_timeout_next;
            r_last_grant <= w_last_grant_next;
            r_grant      <= w_grant_next;
            r_payload    <= w_payload_next;
            r_tx_data    <= w_tx_data_next;
        end
    end

    assign w_finish = (r_state == StDone) || (r_state == StAbort);
    assign ack_t    = w_finish && (r_grant == SrcT);
    assign ack_h    = w_finish && (r_grant == SrcH);
    assign err      = (r_state == StAbort);
    assign tx_start = (r_state == StSend);
    assign tx_data  = r_tx_data;
    assign busy     = (r_state != StIdle);

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Bench for uart_frame_arbiter: UART transmitter model plus a frame/arbitration reference
// built from the packet format and round-robin rules.
module tb_uart_frame_arbiter;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        req_t   = 1'b0;
    logic        req_h   = 1'b0;
    logic        tx_busy = 1'b0;
    logic [15:0] data_t  = 16'h0000;
    logic [15:0] data_h  = 16'h0000;
    logic        ack_t, ack_h, err, tx_start, busy;
    logic [7:0]  tx_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit tx_alive = 1'b1;
    int tx_dly   = 0;
    int tx_len   = 0;
    int stray_acks = 0;

    logic [7:0]  tx_log[$];
    int          start_cyc[$];
    logic        ack_src[$];
    logic        ack_err[$];
    int          ack_cyc[$];
    logic        exp_src[$];
    logic [15:0] exp_pay[$];
    logic        model_last = 1'b1;

    uart_frame_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_t    (req_t),
        .data_t   (data_t),
        .req_h    (req_h),
        .data_h   (data_h),
        .ack_t    (ack_t),
        .ack_h    (ack_h),
        .err      (err),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .busy     (busy)
    );

    always #20 clk = ~clk;

    // Transmitter: busy rises 2 cycles after tx_start and lasts 20 cycles; it ignores rst_n.
    always @(negedge clk) begin
        cyc++;
        if (tx_start) begin
            checks++;
            assert (tx_busy === 1'b0) else begin
                failures++;
                $error("FAIL start_while_busy observed=%0b expected=0", tx_busy);
            end
            tx_log.push_back(tx_data);
            start_cyc.push_back(cyc);
            if (tx_alive) tx_dly = 2;
        end
        if (tx_len > 0) begin
            tx_len--;
            if (tx_len == 0) tx_busy = 1'b0;
        end
        if (tx_dly > 0) begin
            tx_dly--;
            if (tx_dly == 0) begin
                tx_busy = 1'b1;
                tx_len  = 20;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        tx_log.delete();
        start_cyc.delete();
        ack_src.delete();
        ack_err.delete();
        ack_cyc.delete();
        exp_src.delete();
        exp_pay.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_data"}, {24'h0, tx_data}, 32'h00);
        check({tag, "_tx_start"}, {31'h0, tx_start}, 32'h0);
        check({tag, "_ack_t"}, {31'h0, ack_t}, 32'h0);
        check({tag, "_ack_h"}, {31'h0, ack_h}, 32'h0);
        check({tag, "_err"}, {31'h0, err}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_last = 1'b1;
        tick();
    endtask

    // Reference arbitration: both pending -> the one not served last; otherwise whoever asks.
    task automatic predict();
        logic g;
        if (!req_t && !req_h) return;
        if (req_t && req_h) g = ~model_last;
        else g = req_h;
        model_last = g;
        exp_src.push_back(g);
        exp_pay.push_back(g ? data_h : data_t);
    endtask

    task automatic run(input int n, input bit reassert, input int budget);
        int got = 0;
        int cnt = 0;
        while (got < n && cnt < budget) begin
            tick();
            cnt++;
            if (ack_t || ack_h) begin
                got++;
                ack_src.push_back(ack_h);
                ack_err.push_back(err);
                ack_cyc.push_back(cyc);
                if (ack_t) req_t = 1'b0;
                if (ack_h) req_h = 1'b0;
                if (got >= n) begin
                    req_t = 1'b0;
                    req_h = 1'b0;
                end else begin
                    if (reassert && ack_t) begin
                        req_t  = 1'b1;
                        data_t = 16'($urandom());
                    end
                    if (reassert && ack_h) begin
                        req_h  = 1'b1;
                        data_h = 16'($urandom());
                    end
                    predict();
                end
            end
        end
        check("ack_within_budget", got, n);
        tick();
        check("busy_after_frames", {31'h0, busy}, 32'h0);
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int cnt = 0;
        while (tx_log.size() < n && cnt < budget) begin
            tick();
            cnt++;
            if (ack_t || ack_h) stray_acks++;
        end
        check("bytes_within_budget", tx_log.size(), n);
    endtask

    task automatic compare_frames(input string name);
        logic [7:0] exp_bytes[$];
        logic [7:0] tag;
        logic [7:0] hi;
        logic [7:0] lo;
        int         sum;
        int         nb;
        foreach (exp_src[k]) begin
            tag = exp_src[k] ? 8'h48 : 8'h54;
            hi  = exp_pay[k][15:8];
            lo  = exp_pay[k][7:0];
            sum = (int'(tag) + int'(hi) + int'(lo)) % 256;
            exp_bytes.push_back(8'hAA);
            exp_bytes.push_back(tag);
            exp_bytes.push_back(hi);
            exp_bytes.push_back(lo);
            exp_bytes.push_back(sum[7:0]);
        end
        check($sformatf("%s_byte_count", name), tx_log.size(), exp_bytes.size());
        nb = (tx_log.size() < exp_bytes.size()) ? tx_log.size() : exp_bytes.size();
        for (int i = 0; i < nb; i++)
            check($sformatf("%s_byte%0d", name, i), {24'h0, tx_log[i]}, {24'h0, exp_bytes[i]});
        check($sformatf("%s_ack_count", name), ack_src.size(), exp_src.size());
        for (int i = 0; i < ack_src.size() && i < exp_src.size(); i++) begin
            check($sformatf("%s_ack%0d_src", name, i), {31'h0, ack_src[i]}, {31'h0, exp_src[i]});
            check($sformatf("%s_ack%0d_err", name, i), {31'h0, ack_err[i]}, 32'h0);
        end
    endtask

    initial begin
        int pat;
        int n;

        #5 rst_n = 1'b0;
        #10 check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Single temperature frame with the reference payload.
        clear_logs();
        data_t = 16'h1234;
        req_t  = 1'b1;
        predict();
        run(1, 1'b0, 400);
        compare_frames("single_t");

        // Simultaneous requests after reset: T first, then H.
        do_reset();
        clear_logs();
        data_t = 16'($urandom());
        data_h = 16'h8F00;
        req_t  = 1'b1;
        req_h  = 1'b1;
        predict();
        run(2, 1'b0, 800);
        compare_frames("both");

        // Both held and re-requested: grants alternate.
        do_reset();
        clear_logs();
        data_t = 16'($urandom());
        data_h = 16'($urandom());
        req_t  = 1'b1;
        req_h  = 1'b1;
        predict();
        run(4, 1'b1, 1600);
        compare_frames("round_robin");

        // Transmitter never responds: abort after the first byte.
        do_reset();
        clear_logs();
        tx_alive = 1'b0;
        data_h   = 16'($urandom());
        req_h    = 1'b1;
        run(1, 1'b0, 100);
        repeat (30) tick();
        check("abort_starts", tx_log.size(), 1);
        if (tx_log.size() > 0) check("abort_byte", {24'h0, tx_log[0]}, 32'hAA);
        if (ack_src.size() > 0) begin
            check("abort_src", {31'h0, ack_src[0]}, 32'h1);
            check("abort_err", {31'h0, ack_err[0]}, 32'h1);
        end
        if (start_cyc.size() > 0 && ack_cyc.size() > 0)
            check("abort_delay", ack_cyc[0] - start_cyc[0], 9);
        tx_alive = 1'b1;

        // Reset during byte 2, then the same request is framed again from 0xAA.
        do_reset();
        clear_logs();
        stray_acks = 0;
        data_t = 16'($urandom());
        req_t  = 1'b1;
        wait_bytes(3, 300);
        repeat (3) tick();
        rst_n = 1'b0;
        #1 check_reset_outputs("midframe_reset");
        check("no_ack_before_reset", stray_acks, 0);
        tick();
        rst_n = 1'b1;
        model_last = 1'b1;
        clear_logs();
        predict();
        run(1, 1'b0, 500);
        compare_frames("reframe");

        // Request dropped and payload changed while byte 1 is in flight.
        do_reset();
        clear_logs();
        data_t = 16'($urandom());
        req_t  = 1'b1;
        predict();
        wait_bytes(2, 300);
        repeat (2) tick();
        req_t  = 1'b0;
        data_t = ~data_t;
        run(1, 1'b0, 400);
        compare_frames("latched");

        // Random request mixes, round-robin state carried across runs.
        for (int it = 0; it < 6; it++) begin
            clear_logs();
            pat    = $urandom_range(1, 3);
            data_t = 16'($urandom());
            data_h = 16'($urandom());
            req_t  = (pat & 1) != 0;
            req_h  = (pat & 2) != 0;
            n      = (req_t ? 1 : 0) + (req_h ? 1 : 0);
            predict();
            run(n, 1'b0, 800);
            compare_frames($sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_arbiter.md
UART_FRAME_ARBITER -- requirements
Module: uart_frame_arbiter

Interface
REQ-001 SHALL have port clk, input, 1: system clock (25 MHz); all logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port req_t, input, 1: temperature requester frame request, level, held until ack_t.
REQ-004 SHALL have port data_t, input, 16: temperature payload, valid while req_t=1.
REQ-005 SHALL have port req_h, input, 1: humidity requester frame request, level, held until ack_h.
REQ-006 SHALL have port data_h, input, 16: humidity payload, valid while req_h=1.
REQ-007 SHALL have port ack_t, output, 1: one-cycle pulse, temperature frame finished or aborted.
REQ-008 SHALL have port ack_h, output, 1: one-cycle pulse, humidity frame finished or aborted.
REQ-009 SHALL have port err, output, 1: one-cycle pulse, coincident with ack_x on abort.
REQ-010 SHALL have port tx_data, output, 8: byte presented to the UART byte transmitter.
REQ-011 SHALL have port tx_start, output, 1: one-cycle pulse requesting transmission of tx_data.
REQ-012 SHALL have port tx_busy, input, 1: transmitter busy, high from shortly after tx_start until the stop bit completes.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SEND, WAIT_ACC, WAIT_DONE, DONE, ABORT.
REQ-015 IDLE: with tx_busy=0 and at least one req high, SHALL grant, latch the granted 16-bit payload and tag, clear byte_idx to 0, and go to SEND next cycle; with tx_busy=1, SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin:
- Single request: grant it.
- Both requests: grant the source not granted last.
- last_grant SHALL reset to H, so T wins first.
- last_grant SHALL update on the grant.
REQ-017 Frame SHALL be 5 bytes, byte_idx 0..4:
- 0xAA
- tag (0x54 for T, 0x48 for H)
- payload[15:8]
- payload[7:0]
- checksum = (tag + payload[15:8] + payload[7:0]) mod 256
REQ-018 SEND: SHALL assert tx_start=1 for exactly one cycle with tx_data = byte[byte_idx], then go to WAIT_ACC.
REQ-019 tx_data SHALL stay stable from the SEND cycle until the transition out of WAIT_DONE.
REQ-020 WAIT_ACC: on tx_busy=1, SHALL go to WAIT_DONE and clear the timeout counter; otherwise it SHALL increment a 3-bit timeout counter and, on the 8th consecutive cycle without tx_busy, go to ABORT.
REQ-021 WAIT_DONE: on tx_busy=0, SHALL go to SEND with byte_idx+1 if byte_idx<4, else to DONE; no timeout applies.
REQ-022 DONE: SHALL pulse ack of the granted source for one cycle, then go to IDLE.
REQ-023 ABORT: SHALL pulse err and ack of the granted source for one cycle, issue no further tx_start, then go to IDLE.
REQ-024 A requester SHALL deassert req on the edge at which it samples ack=1; the arbiter SHALL NOT re-grant in the DONE/ABORT cycle.
REQ-025 Deassertion of req, or payload change, mid-frame SHALL NOT affect the frame in progress; the latched payload is used.
REQ-026 A new request arriving mid-frame SHALL be held pending and arbitrated in IDLE.
REQ-027 tx_start SHALL never be asserted while tx_busy=1.

Reset
REQ-028 On rst_n=0, SHALL asynchronously force:
- state=IDLE, byte_idx=0, timeout=0, last_grant=H
- tx_data=0x00, tx_start=0, ack_t=0, ack_h=0, err=0, busy=0
REQ-029 Reset mid-frame SHALL abandon the frame without an ack; after release, pending requests are arbitrated afresh.

Verification
REQ-030 Stimulus: req_t=1, data_t=0x1234; bench transmitter model (busy 2 cycles after tx_start, 20 cycles long). Required response: tx_start bytes AA,54,12,34,9A in order, then one ack_t pulse, busy=0 afterwards.
REQ-031 Stimulus: req_t and req_h asserted together after reset, data_h=0x8F00. Required response: T frame first, then H frame AA,48,8F,00,D7; one ack each.
REQ-032 Stimulus: req_t and req_h both held high and re-asserted after each ack for 4 frames. Required response: grants alternate T,H,T,H.
REQ-033 Stimulus: tx_busy tied 0, req_h=1. Required response: single tx_start of 0xAA, then err+ack_h together 8 cycles after WAIT_ACC entry, no further tx_start.
REQ-034 Stimulus: rst_n pulsed low during byte 2 of a frame. Required response: all outputs reset immediately, no ack, and a still-high req is re-framed from 0xAA.
REQ-035 Stimulus: req_t dropped and data_t changed during byte 1. Required response: the frame completes with the originally latched bytes.
